// File: rtl/truth_table_scanner_if.sv
// ----------------------------------------------------------------------------
// truth_table_scanner_if
//   Bundles the control, breadboard and read-back signals of the truth-table
//   scanner. The scanner itself connects through the slave modport; the host
//   (or testbench) connects through the master modport.
//
//   start    host -> scanner   request a full scan
//   busy     scanner -> host   scan in progress
//   done     scanner -> host   one-cycle completion pulse
//   code     scanner -> board  breadboard input code {w,x,y,z}
//   result   board -> scanner  breadboard outputs {r9..r0}
//   rd_addr  host -> scanner   table read address
//   rd_data  scanner -> host   registered table word
//   cnt_sel  host -> scanner   ones-count select
//   cnt_out  scanner -> host   selected ones-count
// ----------------------------------------------------------------------------
interface truth_table_scanner_if #(
    parameter int N_IN  = 4,
    parameter int N_OUT = 10
);
    logic              start;
    logic              busy;
    logic              done;
    logic [N_IN-1:0]   code;
    logic [N_OUT-1:0]  result;
    logic [N_IN-1:0]   rd_addr;
    logic [N_OUT-1:0]  rd_data;
    logic [3:0]        cnt_sel;
    logic [N_IN:0]     cnt_out;

    modport master (
        output start, result, rd_addr, cnt_sel,
        input  busy, done, code, rd_data, cnt_out
    );

    modport slave (
        input  start, result, rd_addr, cnt_sel,
        output busy, done, code, rd_data, cnt_out
    );
endinterface

// File: rtl/truth_table_scanner.sv
// ----------------------------------------------------------------------------
// truth_table_scanner
//   Drives a combinational breadboard through every input code, holds each
//   code for SETTLE_CYCLES cycles, then captures the outputs into a result
//   table and accumulates a per-output ones-count. After the scan the table
//   and the counts can be read back through rd_addr/rd_data and
//   cnt_sel/cnt_out.
//
//   clk  in   single clock, rising edge
//   rst  in   synchronous, active-high reset (aborts a scan, no done)
//   bus  slave modport of truth_table_scanner_if (see interface header)
//
//   Per code the scan spends SETTLE_CYCLES cycles in SETTLE and one in
//   CAPTURE, so DONE is entered 2^N_IN*(SETTLE_CYCLES+1) edges after the
//   edge that sampled start. SETTLE_CYCLES must be at least 1.
// ----------------------------------------------------------------------------
module truth_table_scanner #(
    parameter int N_IN          = 4,
    parameter int N_OUT         = 10,
    parameter int SETTLE_CYCLES = 4
) (
    input logic                  clk,
    input logic                  rst,
    truth_table_scanner_if.slave bus
);
    localparam int DEPTH = 2 ** N_IN;
    localparam int CW    = N_IN + 1;
    localparam int SW    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;

    localparam logic [N_IN-1:0] LAST_CODE   = '1;
    localparam logic [SW-1:0]   SETTLE_LAST = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SETTLE  = 2'd1,
        CAPTURE = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t            state, state_next;
    logic [N_IN-1:0]   code;
    logic [SW-1:0]     settle;
    logic [CW-1:0]     cnt [N_OUT];
    logic [N_OUT-1:0]  tbl [DEPTH];
    logic [N_OUT-1:0]  rd_data;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values, independent of process ordering.
    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_next;
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    // NOTE: state_next gets a default before the case so no path leaves it
    // unassigned, which would otherwise infer a latch.
    always_comb begin
        state_next = state;
        unique case (state)
            IDLE:    if (bus.start) state_next = SETTLE;
            SETTLE:  if (settle == SETTLE_LAST) state_next = CAPTURE;
            CAPTURE: state_next = (code == LAST_CODE) ? DONE : SETTLE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Outputs decoded from state
    // ------------------------------------------------------------------
    always_comb begin
        bus.busy = (state == SETTLE) || (state == CAPTURE);
        bus.done = (state == DONE);
    end

    // ------------------------------------------------------------------
    // Datapath: code, settle counter, result table, ones-counters, read port
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            code    <= '0;
            settle  <= '0;
            rd_data <= '0;
            for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
            // NOTE: the table is a small flop array that must read as zero
            // after reset, so it is cleared here rather than mapped to RAM.
            for (int a = 0; a < DEPTH; a++) tbl[a] <= '0;
        end else begin
            // Read sees the table as of this edge; a same-edge write to the
            // same address shows up one cycle later.
            rd_data <= tbl[bus.rd_addr];

            unique case (state)
                IDLE: begin
                    if (bus.start) begin
                        code   <= '0;
                        settle <= '0;
                        for (int i = 0; i < N_OUT; i++) cnt[i] <= '0;
                    end
                end
                SETTLE: begin
                    settle <= settle + SW'(1);
                end
                CAPTURE: begin
                    tbl[code] <= bus.result;
                    for (int i = 0; i < N_OUT; i++)
                        cnt[i] <= cnt[i] + CW'(bus.result[i]);
                    // The last code is left on the bus after the scan.
                    if (code != LAST_CODE) begin
                        code   <= code + N_IN'(1);
                        settle <= '0;
                    end
                end
                default: ;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Ones-count select; out-of-range selects read as zero
    // ------------------------------------------------------------------
    always_comb begin
        bus.cnt_out = '0;
        for (int i = 0; i < N_OUT; i++)
            if (bus.cnt_sel == 4'(i)) bus.cnt_out = cnt[i];
    end

    assign bus.code    = code;
    assign bus.rd_data = rd_data;

endmodule
